// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared widths, reset PC and counter encodings for the fetch stage
package fetch_stage_pkg;

  localparam int PC_W        = 12;
  localparam int BTB_IDX_W   = 4;
  localparam int BTB_ENTRIES = 1 << BTB_IDX_W;
  localparam int BTB_TAG_W   = PC_W - BTB_IDX_W - 2;

  localparam logic [PC_W-1:0] RESET_PC = 12'h000;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } run_state_e;

  // Saturating step of a 2-bit predictor toward the resolved outcome.
  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    case (c)
      CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  n = taken ? CTR_ST  : CTR_WT;
      default: n = CTR_WNT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - control inputs and IF/ID outputs of the fetch stage
interface fetch_stage_if
  import fetch_stage_pkg::*;
  ();

  logic            stall_i;
  logic            halt_i;
  logic            redirect_i;
  logic [PC_W-1:0] redirect_pc_i;
  logic            upd_valid_i;
  logic [PC_W-1:0] upd_pc_i;
  logic            upd_taken_i;
  logic [PC_W-1:0] upd_target_i;

  logic [PC_W-1:0] imem_addr_o;
  logic [PC_W-1:0] pc_o;
  logic            bpr_o;
  logic [PC_W-1:0] pred_target_o;
  logic            flush_o;

  modport master (
    output stall_i, halt_i, redirect_i, redirect_pc_i,
    output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
    input  imem_addr_o, pc_o, bpr_o, pred_target_o, flush_o
  );

  modport slave (
    input  stall_i, halt_i, redirect_i, redirect_pc_i,
    input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
    output imem_addr_o, pc_o, bpr_o, pred_target_o, flush_o
  );

endinterface

// File: rtl/fetch_stage_btb.sv
// rtl/fetch_stage_btb.sv - direct-mapped BTB with 2-bit counters, async read, sync update
module btb_2bit
  import fetch_stage_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic [PC_W-1:2] rd_pc_i,
  output logic            rd_hit_o,
  output logic            rd_taken_o,
  output logic [PC_W-1:0] rd_target_o,
  input  logic            upd_valid_i,
  input  logic [PC_W-1:2] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [PC_W-1:0] upd_target_i
);

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [BTB_TAG_W-1:0]   tag_q    [BTB_ENTRIES];
  logic [PC_W-1:0]        target_q [BTB_ENTRIES];
  ctr_e                   ctr_q    [BTB_ENTRIES];

  logic [BTB_IDX_W-1:0] rd_idx;
  logic [BTB_TAG_W-1:0] rd_tag;
  logic [BTB_IDX_W-1:0] upd_idx;
  logic [BTB_TAG_W-1:0] upd_tag;

  assign rd_idx  = rd_pc_i[BTB_IDX_W+1:2];
  assign rd_tag  = rd_pc_i[PC_W-1:BTB_IDX_W+2];
  assign upd_idx = upd_pc_i[BTB_IDX_W+1:2];
  assign upd_tag = upd_pc_i[PC_W-1:BTB_IDX_W+2];

  assign rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_taken_o  = ctr_q[rd_idx][1];
  assign rd_target_o = target_q[rd_idx];

  logic            upd_hit;
  logic            upd_we;
  ctr_e            upd_ctr_d;
  logic [PC_W-1:0] upd_target_d;

  // Not-taken misses never allocate, so cold branches stay out of the table.
  always_comb begin
    upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_we       = 1'b0;
    upd_ctr_d    = ctr_q[upd_idx];
    upd_target_d = target_q[upd_idx];
    if (upd_valid_i) begin
      if (upd_hit) begin
        upd_we    = 1'b1;
        upd_ctr_d = ctr_next(ctr_q[upd_idx], upd_taken_i);
        if (upd_taken_i) begin
          upd_target_d = upd_target_i;
        end
      end else if (upd_taken_i) begin
        upd_we       = 1'b1;
        upd_ctr_d    = CTR_WT;
        upd_target_d = upd_target_i;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (upd_we) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target_d;
      ctr_q[upd_idx]    <= upd_ctr_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, halt state and next-PC selection for instruction fetch
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  fetch_stage_if.slave  bus
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  run_state_e      state_q;
  run_state_e      state_d;

  logic            btb_hit;
  logic            btb_taken;
  logic [PC_W-1:0] btb_target;
  logic            bpr;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] pred_target;

  logic unused_upd_lsb;
  assign unused_upd_lsb = ^bus.upd_pc_i[1:0];

  btb_2bit u_btb (
    .CLK          (CLK),
    .RST          (RST),
    .rd_pc_i      (pc_q[PC_W-1:2]),
    .rd_hit_o     (btb_hit),
    .rd_taken_o   (btb_taken),
    .rd_target_o  (btb_target),
    .upd_valid_i  (bus.upd_valid_i),
    .upd_pc_i     (bus.upd_pc_i[PC_W-1:2]),
    .upd_taken_i  (bus.upd_taken_i),
    .upd_target_i (bus.upd_target_i)
  );

  assign pc_plus4    = pc_q + PC_W'(4);
  assign bpr         = btb_hit & btb_taken;
  assign pred_target = bpr ? btb_target : pc_plus4;

  assign bus.imem_addr_o   = pc_q;
  assign bus.pc_o          = pc_q;
  assign bus.bpr_o         = bpr;
  assign bus.pred_target_o = pred_target;
  assign bus.flush_o       = bus.redirect_i;

  // A redirect in the same cycle halt_i rises still lands; after that the PC is frozen.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (bus.halt_i) begin
      state_d = ST_HALTED;
    end
    if (bus.redirect_i && (state_q == ST_RUN)) begin
      pc_d = bus.redirect_pc_i;
    end else if ((state_q == ST_HALTED) || bus.halt_i) begin
      pc_d = pc_q;
    end else if (!bus.stall_i) begin
      pc_d = pred_target;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage against an array-based reference model
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  fetch_stage_if bus ();

  fetch_stage dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    int pc;
    bit bpr;
    int pt;
    bit flush;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   pushed   = 0;
  int   popped   = 0;

  bit m_v   [16];
  int m_tag [16];
  int m_tgt [16];
  int m_ctr [16];
  int m_pc;
  bit m_halted;
  bit m_ok = 0;

  function automatic exp_t model_out();
    exp_t e;
    int   idx;
    bit   hit;
    idx     = (m_pc / 4) % 16;
    hit     = m_v[idx] && (m_tag[idx] == m_pc / 64);
    e.pc    = m_pc;
    e.bpr   = hit && (m_ctr[idx] >= 2);
    e.pt    = e.bpr ? m_tgt[idx] : (m_pc + 4) % 4096;
    e.flush = bus.redirect_i;
    return e;
  endfunction

  function automatic void model_commit();
    exp_t e;
    int   ui;
    int   ut;
    if (RST) begin
      m_pc     = 0;
      m_halted = 0;
      for (int i = 0; i < 16; i++) begin
        m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      return;
    end
    e = model_out();
    if (bus.redirect_i && !m_halted) m_pc = int'(bus.redirect_pc_i);
    else if (m_halted || bus.halt_i) m_pc = m_pc;
    else if (!bus.stall_i) m_pc = e.pt;
    if (bus.halt_i) m_halted = 1;
    if (bus.upd_valid_i) begin
      ui = (int'(bus.upd_pc_i) / 4) % 16;
      ut = int'(bus.upd_pc_i) / 64;
      if (m_v[ui] && m_tag[ui] == ut) begin
        if (bus.upd_taken_i) begin
          m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
          m_tgt[ui] = int'(bus.upd_target_i);
        end else begin
          m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
        end
      end else if (bus.upd_taken_i) begin
        m_v[ui] = 1; m_tag[ui] = ut; m_tgt[ui] = int'(bus.upd_target_i); m_ctr[ui] = 2;
      end
    end
  endfunction

  task automatic drive(input bit rst, input bit stall, input bit halt, input bit redir,
                       input int rpc, input bit uv, input int upc, input bit ut, input int utgt);
    RST               = rst;
    bus.stall_i       = stall;
    bus.halt_i        = halt;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = 12'(rpc);
    bus.upd_valid_i   = uv;
    bus.upd_pc_i      = 12'(upc);
    bus.upd_taken_i   = ut;
    bus.upd_target_i  = 12'(utgt);
    if (m_ok) begin
      exp_q.push_back(model_out());
      pushed++;
    end
    @(posedge CLK);
    #1;
    model_commit();
    if (rst) m_ok = 1;
  endtask

  task automatic idle();                  drive(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic stall();                 drive(0, 1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic redir(input int pc);     drive(0, 0, 0, 1, pc, 0, 0, 0, 0); endtask
  task automatic upd(input int pc, input bit t, input int tgt);
    drive(0, 0, 0, 0, 0, 1, pc, t, tgt);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      popped++;
      chk("imem_addr", 32'(bus.imem_addr_o), 32'(e.pc));
      chk("pc", 32'(bus.pc_o), 32'(e.pc));
      chk("bpr", 32'(bus.bpr_o), 32'(e.bpr));
      chk("pred_target", 32'(bus.pred_target_o), 32'(e.pt));
      chk("flush", 32'(bus.flush_o), 32'(e.flush));
    end
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(); idle();
    repeat (3) stall();
    drive(0, 1, 0, 1, 12'h040, 0, 0, 0, 0);
    idle();
    upd(12'h010, 1, 12'h080);
    redir(12'h008);
    idle(); idle(); idle();
    upd(12'h010, 0, 0);
    upd(12'h010, 0, 0);
    redir(12'h010);
    idle();
    upd(12'h010, 1, 12'h080);
    redir(12'h010);
    upd(12'h010, 1, 12'h080);
    redir(12'h010);
    idle();
    redir(12'h050);
    idle();
    redir(12'hFF8);
    idle(); idle();
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(); idle();
    redir(12'h040);
    idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) idle();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 79) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 63) * 4, $urandom_range(0, 1) == 1,
            $urandom_range(0, 63) * 4, $urandom_range(0, 2) != 0,
            $urandom_range(0, 63) * 4);
    end
    idle();
    @(posedge CLK);
    #1;
    chk("scoreboard_drained", 32'(popped), 32'(pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
